// File: rtl/hold_ctrl.sv
// rtl/hold_ctrl.sv - pipeline hold/redirect arbiter with debug halt FSM, bus timeout and stall counter
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   jtag_reset_flag_i        debug reset: FSM to RUN, drain/bus-timeout state cleared
//   ex_jump_flag_i/addr_i    execute-stage redirect request and target
//   ex_hold_i                execute-stage multi-cycle stall
//   clint_int_assert_i/addr  interrupt redirect request and target
//   clint_hold_i             interrupt controller stall
//   rib_hold_i               bus arbiter stall
//   jtag_halt_i              debug halt request (level)
//   stall_clr_i              clear stall counter
//   jump_flag_o/addr_o       merged redirect to PC register
//   hold_flag_o              merged pipeline hold level
//   halted_o                 core halted for debug
//   bus_timeout_o            one-cycle pulse on bus-hold timeout
//   stall_cnt_o              saturating count of held cycles

module hold_ctrl #(
  parameter int InstAddrBus   = 32,
  parameter int Hold_Flag_Bus = 3,
  parameter int DRAIN_CYCLES  = 3,
  parameter int BUS_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jtag_reset_flag_i,
  input  logic                     ex_jump_flag_i,
  input  logic [InstAddrBus-1:0]   ex_jump_addr_i,
  input  logic                     ex_hold_i,
  input  logic                     clint_int_assert_i,
  input  logic [InstAddrBus-1:0]   clint_int_addr_i,
  input  logic                     clint_hold_i,
  input  logic                     rib_hold_i,
  input  logic                     jtag_halt_i,
  input  logic                     stall_clr_i,
  output logic                     jump_flag_o,
  output logic [InstAddrBus-1:0]   jump_addr_o,
  output logic [Hold_Flag_Bus-1:0] hold_flag_o,
  output logic                     halted_o,
  output logic                     bus_timeout_o,
  output logic [31:0]              stall_cnt_o
);

  localparam logic [Hold_Flag_Bus-1:0] HOLD_NONE = Hold_Flag_Bus'(0);
  localparam logic [Hold_Flag_Bus-1:0] HOLD_PC   = Hold_Flag_Bus'(1);
  localparam logic [Hold_Flag_Bus-1:0] HOLD_ID   = Hold_Flag_Bus'(3);

  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [15:0] BUS_LIMIT  = 16'(BUS_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_RESUME
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [3:0]               r_drain_cnt;
  logic [3:0]               w_drain_cnt_next;
  logic [15:0]              r_bus_cnt;
  logic                     r_bus_timeout;
  logic [31:0]              r_stall_cnt;
  logic                     w_jump;
  logic [Hold_Flag_Bus-1:0] w_hold_ext;
  logic [Hold_Flag_Bus-1:0] w_hold_fsm;
  logic [Hold_Flag_Bus-1:0] w_hold;

  assign w_jump      = ex_jump_flag_i | clint_int_assert_i;
  assign jump_flag_o = w_jump;
  // Interrupt redirect wins over an execute-stage jump in the same cycle.
  assign jump_addr_o = clint_int_assert_i ? clint_int_addr_i : ex_jump_addr_i;

  always_comb begin
    w_hold_ext = HOLD_NONE;
    if (ex_hold_i || clint_hold_i) begin
      w_hold_ext = HOLD_ID;
    end else if (rib_hold_i) begin
      w_hold_ext = HOLD_PC;
    end

    // The FSM stays silent while reset is applied, even if it still
    // holds a stale DRAIN/HALTED state from before the reset edge.
    w_hold_fsm = HOLD_NONE;
    if (!rst) begin
      case (r_state)
        S_DRAIN:  w_hold_fsm = HOLD_PC;
        S_HALTED: w_hold_fsm = HOLD_ID;
        default:  w_hold_fsm = HOLD_NONE;
      endcase
    end

    w_hold = (w_hold_ext > w_hold_fsm) ? w_hold_ext : w_hold_fsm;
  end

  assign hold_flag_o = w_hold;

  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    case (r_state)
      S_RUN: begin
        if (jtag_halt_i) begin
          w_state_next     = S_DRAIN;
          w_drain_cnt_next = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (!jtag_halt_i) begin
          w_state_next     = S_RUN;
          w_drain_cnt_next = 4'd0;
        end else if (w_jump) begin
          // A redirect refills the fetch path, so draining starts over.
          w_drain_cnt_next = DRAIN_LOAD;
        end else if (r_drain_cnt == 4'd0) begin
          w_state_next = S_HALTED;
        end else if (!ex_hold_i && !rib_hold_i) begin
          w_drain_cnt_next = r_drain_cnt - 4'd1;
        end
      end
      S_HALTED: begin
        if (!jtag_halt_i) begin
          w_state_next = S_RESUME;
        end
      end
      S_RESUME: begin
        w_state_next = S_RUN;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase

    if (jtag_reset_flag_i) begin
      w_state_next     = S_RUN;
      w_drain_cnt_next = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_drain_cnt   <= 4'd0;
      r_bus_cnt     <= 16'd0;
      r_bus_timeout <= 1'b0;
      r_stall_cnt   <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;

      if (jtag_reset_flag_i || !rib_hold_i) begin
        r_bus_cnt     <= 16'd0;
        r_bus_timeout <= 1'b0;
      end else begin
        if (r_bus_cnt != BUS_LIMIT) begin
          r_bus_cnt <= r_bus_cnt + 16'd1;
        end
        // Fires only on the step into the limit; saturation keeps it from repeating.
        r_bus_timeout <= (r_bus_cnt == BUS_LIMIT - 16'd1);
      end

      if (stall_clr_i) begin
        r_stall_cnt <= 32'd0;
      end else if ((w_hold != HOLD_NONE) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign halted_o      = (r_state == S_HALTED);
  assign bus_timeout_o = r_bus_timeout;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_hold_ctrl.sv
// tb/tb_hold_ctrl.sv - self-checking bench for hold_ctrl with behavioural reference model

module tb_hold_ctrl;

  localparam int DRAIN = 3;
  localparam int BTO   = 4;

  logic        clk;
  logic        rst;
  logic        jtag_reset_flag_i;
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_hold_i;
  logic        clint_int_assert_i;
  logic [31:0] clint_int_addr_i;
  logic        clint_hold_i;
  logic        rib_hold_i;
  logic        jtag_halt_i;
  logic        stall_clr_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  hold_flag_o;
  logic        halted_o;
  logic        bus_timeout_o;
  logic [31:0] stall_cnt_o;

  int total;
  int bad;

  // Reference model state
  bit     m_draining;
  bit     m_halted;
  bit     m_resume;
  int     m_left;
  int     m_run_len;
  bit     m_pulse;
  longint m_stall;

  hold_ctrl #(
    .InstAddrBus  (32),
    .Hold_Flag_Bus(3),
    .DRAIN_CYCLES (DRAIN),
    .BUS_TIMEOUT  (BTO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .jtag_reset_flag_i (jtag_reset_flag_i),
    .ex_jump_flag_i    (ex_jump_flag_i),
    .ex_jump_addr_i    (ex_jump_addr_i),
    .ex_hold_i         (ex_hold_i),
    .clint_int_assert_i(clint_int_assert_i),
    .clint_int_addr_i  (clint_int_addr_i),
    .clint_hold_i      (clint_hold_i),
    .rib_hold_i        (rib_hold_i),
    .jtag_halt_i       (jtag_halt_i),
    .stall_clr_i       (stall_clr_i),
    .jump_flag_o       (jump_flag_o),
    .jump_addr_o       (jump_addr_o),
    .hold_flag_o       (hold_flag_o),
    .halted_o          (halted_o),
    .bus_timeout_o     (bus_timeout_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int m_hold_exp();
    int h;
    h = 0;
    if (ex_hold_i || clint_hold_i) h = 3;
    else if (rib_hold_i) h = 1;
    if (!rst) begin
      if (m_halted && h < 3) h = 3;
      else if (m_draining && h < 1) h = 1;
    end
    return h;
  endfunction

  task automatic model_update();
    int h;
    bit jump;
    h    = m_hold_exp();
    jump = ex_jump_flag_i || clint_int_assert_i;
    if (rst) begin
      m_draining = 0; m_halted = 0; m_resume = 0; m_left = 0;
      m_run_len = 0; m_pulse = 0; m_stall = 0;
    end else begin
      if (stall_clr_i) m_stall = 0;
      else if (h != 0 && m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
      if (jtag_reset_flag_i) begin
        m_draining = 0; m_halted = 0; m_resume = 0; m_left = 0;
        m_run_len = 0; m_pulse = 0;
      end else begin
        m_run_len = rib_hold_i ? m_run_len + 1 : 0;
        m_pulse   = (m_run_len == BTO);
        if (m_resume) begin
          m_resume = 0;
        end else if (m_halted) begin
          if (!jtag_halt_i) begin m_halted = 0; m_resume = 1; end
        end else if (m_draining) begin
          if (!jtag_halt_i) m_draining = 0;
          else if (jump) m_left = DRAIN;
          else if (m_left == 0) begin m_draining = 0; m_halted = 1; end
          else if (!ex_hold_i && !rib_hold_i) m_left = m_left - 1;
        end else if (jtag_halt_i) begin
          m_draining = 1;
          m_left     = DRAIN;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    jtag_reset_flag_i = 0; ex_jump_flag_i = 0; ex_jump_addr_i = 0; ex_hold_i = 0;
    clint_int_assert_i = 0; clint_int_addr_i = 0; clint_hold_i = 0; rib_hold_i = 0;
    stall_clr_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    jtag_halt_i = 0;
    rst = 1;
    tick();
    tick();
    #1;
    total++; if (halted_o !== 1'b0) begin bad++; $display("FAIL reset_halted: got %0h want 0", halted_o); end
    total++; if (bus_timeout_o !== 1'b0) begin bad++; $display("FAIL reset_bus_timeout: got %0h want 0", bus_timeout_o); end
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt: got %0h want 0", stall_cnt_o); end
    total++; if (hold_flag_o !== 3'd0) begin bad++; $display("FAIL reset_hold: got %0h want 0", hold_flag_o); end
    total++; if (jump_flag_o !== 1'b0) begin bad++; $display("FAIL reset_jump: got %0h want 0", jump_flag_o); end
    rst = 0;
    tick();
  endtask

  task automatic test_jump_priority();
    logic [31:0] a;
    logic [31:0] b;
    clear_inputs();
    ex_jump_flag_i = 1; ex_jump_addr_i = 32'h100;
    clint_int_assert_i = 1; clint_int_addr_i = 32'h200;
    #1;
    total++; if (jump_flag_o !== 1'b1) begin bad++; $display("FAIL jump_collide_flag: got %0h want 1", jump_flag_o); end
    total++; if (jump_addr_o !== 32'h200) begin bad++; $display("FAIL jump_collide_addr: got %0h want 200", jump_addr_o); end
    tick();
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      ex_jump_flag_i = i[0]; clint_int_assert_i = i[1];
      ex_jump_addr_i = a; clint_int_addr_i = b;
      #1;
      total++;
      if (jump_flag_o !== (i[0] | i[1])) begin bad++; $display("FAIL jump_flag_%0d: got %0h want %0h", i, jump_flag_o, i[0] | i[1]); end
      total++;
      if (jump_addr_o !== (i[1] ? b : a)) begin bad++; $display("FAIL jump_addr_%0d: got %0h want %0h", i, jump_addr_o, i[1] ? b : a); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_hold_merge();
    clear_inputs();
    rib_hold_i = 1; ex_hold_i = 1;
    #1;
    total++; if (hold_flag_o !== 3'd3) begin bad++; $display("FAIL hold_rib_ex: got %0h want 3", hold_flag_o); end
    tick();
    ex_hold_i = 0;
    #1;
    total++; if (hold_flag_o !== 3'd1) begin bad++; $display("FAIL hold_rib_only: got %0h want 1", hold_flag_o); end
    tick();
    rib_hold_i = 0; clint_hold_i = 1;
    #1;
    total++; if (hold_flag_o !== 3'd3) begin bad++; $display("FAIL hold_clint: got %0h want 3", hold_flag_o); end
    tick();
    clint_hold_i = 0;
    #1;
    total++; if (hold_flag_o !== 3'd0) begin bad++; $display("FAIL hold_none: got %0h want 0", hold_flag_o); end
    tick();
  endtask

  task automatic test_halt_sequence();
    clear_inputs();
    jtag_halt_i = 1;
    #1;
    total++; if (hold_flag_o !== 3'd0) begin bad++; $display("FAIL halt_req_run_hold: got %0h want 0", hold_flag_o); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      total++; if (hold_flag_o !== 3'd1) begin bad++; $display("FAIL halt_drain_hold_%0d: got %0h want 1", i, hold_flag_o); end
      total++; if (halted_o !== 1'b0) begin bad++; $display("FAIL halt_drain_halted_%0d: got %0h want 0", i, halted_o); end
      tick();
    end
    #1;
    total++; if (halted_o !== 1'b1) begin bad++; $display("FAIL halt_granted: got %0h want 1", halted_o); end
    total++; if (hold_flag_o !== 3'd3) begin bad++; $display("FAIL halt_hold_id: got %0h want 3", hold_flag_o); end
    jtag_halt_i = 0;
    tick();
    jtag_halt_i = 1;
    #1;
    total++; if (hold_flag_o !== 3'd0) begin bad++; $display("FAIL resume_hold: got %0h want 0", hold_flag_o); end
    total++; if (halted_o !== 1'b0) begin bad++; $display("FAIL resume_halted: got %0h want 0", halted_o); end
    tick();
    jtag_halt_i = 0;
    #1;
    total++; if (hold_flag_o !== 3'd0) begin bad++; $display("FAIL resume_to_run_hold: got %0h want 0", hold_flag_o); end
    tick();
    tick();
  endtask

  task automatic test_drain_stall_jump();
    clear_inputs();
    jtag_halt_i = 1;
    tick();
    for (int i = 1; i <= 11; i++) begin
      ex_hold_i      = (i <= 5);
      ex_jump_flag_i = (i == 7);
      ex_jump_addr_i = 32'h40;
      #1;
      total++; if (halted_o !== 1'b0) begin bad++; $display("FAIL drain_stall_halted_%0d: got %0h want 0", i, halted_o); end
      total++;
      if (hold_flag_o !== ((i <= 5) ? 3'd3 : 3'd1)) begin
        bad++; $display("FAIL drain_stall_hold_%0d: got %0h want %0h", i, hold_flag_o, (i <= 5) ? 3'd3 : 3'd1);
      end
      tick();
    end
    clear_inputs();
    #1;
    total++; if (halted_o !== 1'b1) begin bad++; $display("FAIL drain_stall_granted: got %0h want 1", halted_o); end
    jtag_halt_i = 0;
    tick();
    tick();
    jtag_halt_i = 1;
    tick();
    tick();
    jtag_halt_i = 0;
    #1;
    total++; if (hold_flag_o !== 3'd1) begin bad++; $display("FAIL drain_abort_hold: got %0h want 1", hold_flag_o); end
    tick();
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (halted_o !== 1'b0) begin bad++; $display("FAIL drain_abort_halted_%0d: got %0h want 0", i, halted_o); end
      total++; if (hold_flag_o !== 3'd0) begin bad++; $display("FAIL drain_abort_run_%0d: got %0h want 0", i, hold_flag_o); end
      tick();
    end
  endtask

  task automatic test_bus_timeout();
    clear_inputs();
    jtag_halt_i = 0;
    stall_clr_i = 1;
    tick();
    stall_clr_i = 0;
    rib_hold_i  = 1;
    for (int i = 1; i <= 10; i++) begin
      #1;
      total++;
      if (bus_timeout_o !== (i == 5)) begin bad++; $display("FAIL bus_timeout_cyc%0d: got %0h want %0h", i, bus_timeout_o, i == 5); end
      tick();
    end
    rib_hold_i = 0;
    #1;
    total++; if (bus_timeout_o !== 1'b0) begin bad++; $display("FAIL bus_timeout_after: got %0h want 0", bus_timeout_o); end
    total++; if (stall_cnt_o !== 32'd10) begin bad++; $display("FAIL stall_cnt_10: got %0d want 10", stall_cnt_o); end
    stall_clr_i = 1;
    tick();
    stall_clr_i = 0;
    #1;
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL stall_clr: got %0d want 0", stall_cnt_o); end
    tick();
  endtask

  task automatic test_reset_halted();
    clear_inputs();
    stall_clr_i = 1;
    tick();
    stall_clr_i = 0;
    jtag_halt_i = 1;
    for (int i = 0; i < 8; i++) tick();
    #1;
    total++; if (halted_o !== 1'b1) begin bad++; $display("FAIL rst_pre_halted: got %0h want 1", halted_o); end
    total++; if (stall_cnt_o !== 32'd7) begin bad++; $display("FAIL rst_pre_stall: got %0d want 7", stall_cnt_o); end
    rst = 1;
    #1;
    total++; if (hold_flag_o !== 3'd0) begin bad++; $display("FAIL rst_comb_hold: got %0h want 0", hold_flag_o); end
    tick();
    #1;
    total++; if (halted_o !== 1'b0) begin bad++; $display("FAIL rst_halted: got %0h want 0", halted_o); end
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL rst_stall: got %0d want 0", stall_cnt_o); end
    rst = 0;
    jtag_halt_i = 0;
    #1;
    total++; if (hold_flag_o !== 3'd0) begin bad++; $display("FAIL rst_run_hold: got %0h want 0", hold_flag_o); end
    tick();
  endtask

  task automatic test_random();
    int exp_hold;
    for (int i = 0; i < 800; i++) begin
      rst                = ($urandom_range(0, 99) == 0);
      jtag_reset_flag_i  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) jtag_halt_i = ~jtag_halt_i;
      if ($urandom_range(0, 4) == 0) rib_hold_i = ~rib_hold_i;
      ex_hold_i          = ($urandom_range(0, 5) == 0);
      clint_hold_i       = ($urandom_range(0, 11) == 0);
      ex_jump_flag_i     = ($urandom_range(0, 5) == 0);
      clint_int_assert_i = ($urandom_range(0, 9) == 0);
      ex_jump_addr_i     = $urandom;
      clint_int_addr_i   = $urandom;
      stall_clr_i        = ($urandom_range(0, 49) == 0);
      #1;
      exp_hold = m_hold_exp();
      total++;
      if (jump_flag_o !== (ex_jump_flag_i | clint_int_assert_i)) begin
        bad++; $display("FAIL rnd_jump_flag@%0d: got %0h want %0h", i, jump_flag_o, ex_jump_flag_i | clint_int_assert_i);
      end
      total++;
      if (jump_addr_o !== (clint_int_assert_i ? clint_int_addr_i : ex_jump_addr_i)) begin
        bad++; $display("FAIL rnd_jump_addr@%0d: got %0h want %0h", i, jump_addr_o, clint_int_assert_i ? clint_int_addr_i : ex_jump_addr_i);
      end
      total++;
      if (hold_flag_o !== 3'(exp_hold)) begin bad++; $display("FAIL rnd_hold@%0d: got %0h want %0h", i, hold_flag_o, exp_hold); end
      total++;
      if (halted_o !== m_halted) begin bad++; $display("FAIL rnd_halted@%0d: got %0h want %0h", i, halted_o, m_halted); end
      total++;
      if (bus_timeout_o !== m_pulse) begin bad++; $display("FAIL rnd_bus_timeout@%0d: got %0h want %0h", i, bus_timeout_o, m_pulse); end
      total++;
      if (stall_cnt_o !== 32'(m_stall)) begin bad++; $display("FAIL rnd_stall@%0d: got %0d want %0d", i, stall_cnt_o, m_stall); end
      tick();
    end
    rst = 0;
    clear_inputs();
    jtag_halt_i = 0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_draining = 0; m_halted = 0; m_resume = 0; m_left = 0;
    m_run_len = 0; m_pulse = 0; m_stall = 0;
    rst = 1;
    jtag_halt_i = 0;
    clear_inputs();
    test_reset();
    test_jump_priority();
    test_hold_merge();
    test_halt_sequence();
    test_drain_stall_jump();
    test_bus_timeout();
    test_reset_halted();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
